// File: rtl/note_player_pkg.sv
// rtl/note_player_pkg.sv - shared types and constants for the note player voice
package note_player_pkg;

  localparam int PHASE_W    = 20;
  localparam int SAMPLE_W   = 16;
  localparam int NOTE_W     = 6;
  localparam int TRI_OFFSET = 16384;

  typedef enum logic {
    IDLE,
    PLAYING
  } state_t;

endpackage

// File: rtl/frequency_rom.sv
// rtl/frequency_rom.sv - pitch code to phase step, step = round(f * 2^20 / 48000)
module frequency_rom
  import note_player_pkg::*;
(
  input  logic [NOTE_W-1:0]  note,
  output logic [PHASE_W-1:0] step
);

  // Code 49 is A4 (440 Hz); code 0 is a rest and never advances the phase.
  always_comb begin
    step = '0;
    case (note)
      6'd0:  step = 20'd0;
      6'd1:  step = 20'd601;
      6'd2:  step = 20'd636;
      6'd3:  step = 20'd674;
      6'd4:  step = 20'd714;
      6'd5:  step = 20'd757;
      6'd6:  step = 20'd802;
      6'd7:  step = 20'd850;
      6'd8:  step = 20'd900;
      6'd9:  step = 20'd954;
      6'd10: step = 20'd1010;
      6'd11: step = 20'd1070;
      6'd12: step = 20'd1134;
      6'd13: step = 20'd1201;
      6'd14: step = 20'd1273;
      6'd15: step = 20'd1349;
      6'd16: step = 20'd1429;
      6'd17: step = 20'd1514;
      6'd18: step = 20'd1604;
      6'd19: step = 20'd1699;
      6'd20: step = 20'd1800;
      6'd21: step = 20'd1907;
      6'd22: step = 20'd2021;
      6'd23: step = 20'd2141;
      6'd24: step = 20'd2268;
      6'd25: step = 20'd2403;
      6'd26: step = 20'd2546;
      6'd27: step = 20'd2697;
      6'd28: step = 20'd2858;
      6'd29: step = 20'd3028;
      6'd30: step = 20'd3208;
      6'd31: step = 20'd3398;
      6'd32: step = 20'd3600;
      6'd33: step = 20'd3815;
      6'd34: step = 20'd4041;
      6'd35: step = 20'd4282;
      6'd36: step = 20'd4536;
      6'd37: step = 20'd4806;
      6'd38: step = 20'd5092;
      6'd39: step = 20'd5395;
      6'd40: step = 20'd5715;
      6'd41: step = 20'd6055;
      6'd42: step = 20'd6415;
      6'd43: step = 20'd6797;
      6'd44: step = 20'd7201;
      6'd45: step = 20'd7629;
      6'd46: step = 20'd8083;
      6'd47: step = 20'd8563;
      6'd48: step = 20'd9072;
      6'd49: step = 20'd9612;
      6'd50: step = 20'd10184;
      6'd51: step = 20'd10789;
      6'd52: step = 20'd11431;
      6'd53: step = 20'd12110;
      6'd54: step = 20'd12830;
      6'd55: step = 20'd13593;
      6'd56: step = 20'd14402;
      6'd57: step = 20'd15258;
      6'd58: step = 20'd16165;
      6'd59: step = 20'd17127;
      6'd60: step = 20'd18145;
      6'd61: step = 20'd19224;
      6'd62: step = 20'd20367;
      6'd63: step = 20'd21578;
      default: step = '0;
    endcase
  end

endmodule

// File: rtl/note_player.sv
// rtl/note_player.sv - one triangle-wave voice driven by the song_reader note stream
module note_player #(
  parameter int PHASE_W  = note_player_pkg::PHASE_W,
  parameter int SAMPLE_W = note_player_pkg::SAMPLE_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                play_enable,
  input  logic                                new_note,
  input  logic [note_player_pkg::NOTE_W-1:0]  note,
  input  logic [note_player_pkg::NOTE_W-1:0]  duration,
  input  logic                                beat,
  input  logic                                generate_next_sample,
  output logic                                note_done,
  output logic                                new_sample_ready,
  output logic [SAMPLE_W-1:0]                 sample_out
);

  import note_player_pkg::*;

  localparam int T_W = SAMPLE_W - 1;

  state_t                             state;
  logic [PHASE_W-1:0]                 phase;
  logic [NOTE_W-1:0]                  remaining;
  logic [NOTE_W-1:0]                  cur_note;
  logic [note_player_pkg::PHASE_W-1:0] rom_step;
  logic [T_W-1:0]                     tri_t;
  logic [SAMPLE_W-1:0]                tri_val;

  frequency_rom u_frequency_rom (
    .note (cur_note),
    .step (rom_step)
  );

  // Rising half of the period climbs from -16384, falling half descends from 16383.
  assign tri_t   = phase[PHASE_W-2 -: T_W];
  assign tri_val = phase[PHASE_W-1] ? (SAMPLE_W'(TRI_OFFSET - 1) - {1'b0, tri_t})
                                    : ({1'b0, tri_t} - SAMPLE_W'(TRI_OFFSET));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      phase            <= '0;
      remaining        <= '0;
      cur_note         <= '0;
      note_done        <= 1'b0;
      new_sample_ready <= 1'b0;
      sample_out       <= '0;
    end else begin
      note_done        <= 1'b0;
      new_sample_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (new_note) begin
            cur_note  <= note;
            remaining <= duration;
            phase     <= '0;
            state     <= PLAYING;
          end
        end
        PLAYING: begin
          if (play_enable) begin
            if (generate_next_sample) begin
              sample_out       <= (cur_note == '0) ? '0 : tri_val;
              phase            <= phase + PHASE_W'(rom_step);
              new_sample_ready <= 1'b1;
            end
            // A reload restarts the note and overrides any expiry in the same cycle.
            if (new_note) begin
              cur_note  <= note;
              remaining <= duration;
              phase     <= '0;
            end else if (remaining == '0 || (beat && remaining == NOTE_W'(1))) begin
              note_done <= 1'b1;
              state     <= IDLE;
            end else if (beat) begin
              remaining <= remaining - NOTE_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - randomized and directed self-checking bench for note_player
module tb_note_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        beat;
  logic        generate_next_sample;
  logic        note_done;
  logic        new_sample_ready;
  logic [15:0] sample_out;

  int checks   = 0;
  int failures = 0;

  bit m_play;
  int m_rem, m_note, m_phase, m_sample;
  int tick_no, done_seen, done_tick, rdy_seen, last_sample;

  note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .new_note             (new_note),
    .note                 (note),
    .duration             (duration),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .note_done            (note_done),
    .new_sample_ready     (new_sample_ready),
    .sample_out           (sample_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int step_of(input int n);
    real f;
    if (n == 0) return 0;
    f = 440.0 * (2.0 ** ((n - 49) / 12.0));
    return int'($floor(f * 1048576.0 / 48000.0 + 0.5));
  endfunction

  function automatic int tri_of(input int ph);
    int t;
    t = (ph % 524288) / 16;
    return (ph >= 524288) ? (16383 - t) : (t - 16384);
  endfunction

  function automatic int out_sample();
    return int'($signed(sample_out));
  endfunction

  task automatic model_load(input int nt, input int du);
    m_play  = 1'b1;
    m_note  = nt;
    m_rem   = du;
    m_phase = 0;
  endtask

  // One clock: drive inputs, advance the reference model, then compare after the edge.
  task automatic tick(input bit nn, input int nt, input int du, input bit bt, input bit gn, input bit en);
    int e_done;
    int e_rdy;
    new_note             = nn;
    note                 = nt[5:0];
    duration             = du[5:0];
    beat                 = bt;
    generate_next_sample = gn;
    play_enable          = en;
    e_done = 0;
    e_rdy  = 0;
    if (reset == 1'b0) begin
      m_play = 1'b0; m_rem = 0; m_note = 0; m_phase = 0; m_sample = 0;
    end else if (!m_play) begin
      if (nn) model_load(nt, du);
    end else if (en) begin
      if (gn) begin
        e_rdy    = 1;
        m_sample = (m_note == 0) ? 0 : tri_of(m_phase);
        m_phase  = (m_phase + step_of(m_note)) % 1048576;
      end
      if (nn) model_load(nt, du);
      else if (m_rem == 0 || (bt && m_rem == 1)) begin
        e_done = 1;
        m_play = 1'b0;
      end else if (bt) m_rem--;
    end
    @(posedge clk);
    #1;
    tick_no++;
    check("note_done", int'(note_done), e_done);
    check("new_sample_ready", int'(new_sample_ready), e_rdy);
    check("sample_out", out_sample(), m_sample);
    if (note_done) begin
      done_seen++;
      done_tick = tick_no;
    end
    if (new_sample_ready) begin
      rdy_seen++;
      last_sample = out_sample();
    end
  endtask

  initial begin
    int base;
    int rdy_before;
    bit nn, bt, gn, en;
    int nt, du;

    m_play = 1'b0; m_rem = 0; m_note = 0; m_phase = 0; m_sample = 0;
    tick_no = 0; done_seen = 0; done_tick = -1; rdy_seen = 0; last_sample = 0;
    reset = 1'b0; play_enable = 1'b1; new_note = 1'b0; note = '0; duration = '0;
    beat = 1'b0; generate_next_sample = 1'b0;
    #1;
    check("reset_note_done", int'(note_done), 0);
    check("reset_ready", int'(new_sample_ready), 0);
    check("reset_sample", out_sample(), 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    reset = 1'b1;

    // Three beats, one every four cycles: exactly one note_done, after the third.
    done_seen = 0;
    tick(1, 49, 3, 0, 0, 1);
    base = tick_no;
    for (int i = 0; i < 16; i++) tick(0, 0, 0, (i % 4) == 3, 0, 1);
    check("dur3_done_count", done_seen, 1);
    check("dur3_done_tick", done_tick, base + 12);

    // Reset mid-note: outputs clear at once and nothing fires after release.
    tick(1, 49, 5, 0, 0, 1);
    tick(0, 0, 0, 1, 1, 1);
    tick(0, 0, 0, 1, 1, 1);
    tick(0, 0, 0, 0, 1, 1);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_note_done", int'(note_done), 0);
    check("midreset_ready", int'(new_sample_ready), 0);
    check("midreset_sample", out_sample(), 0);
    tick(0, 0, 0, 1, 1, 1);
    reset = 1'b1;
    done_seen = 0;
    rdy_seen  = 0;
    for (int i = 0; i < 20; i++) tick(0, 0, 0, (i % 4) == 0, (i % 3) == 0, 1);
    check("postreset_no_done", done_seen, 0);
    check("postreset_no_samples", rdy_seen, 0);

    // Load while disabled in IDLE, then freeze mid-note for 5 beats and 20 requests.
    tick(1, 49, 4, 0, 0, 0);
    tick(0, 0, 0, 1, 1, 1);
    done_seen  = 0;
    rdy_before = rdy_seen;
    for (int i = 0; i < 25; i++) tick(0, 0, 0, (i % 5) == 0, (i % 5) != 0, 0);
    check("frozen_no_done", done_seen, 0);
    check("frozen_no_samples", rdy_seen, rdy_before);
    base = tick_no;
    for (int i = 0; i < 16; i++) tick(0, 0, 0, (i % 4) == 3, 0, 1);
    check("resume_done_count", done_seen, 1);
    check("resume_done_tick", done_tick, base + 12);

    // Zero duration: note_done in cycle L+2.
    done_seen = 0;
    base = tick_no;
    tick(1, 5, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 1);
    check("dur0_done_count", done_seen, 1);
    check("dur0_done_tick", done_tick, base + 2);

    // Reload on the final beat suppresses note_done; the new note runs its full length.
    done_seen = 0;
    tick(1, 49, 2, 0, 0, 1);
    tick(0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(1, 30, 2, 1, 0, 1);
    check("reload_no_done", done_seen, 0);
    base = tick_no;
    for (int i = 0; i < 10; i++) tick(0, 0, 0, (i % 4) == 3, 0, 1);
    check("reload_done_count", done_seen, 1);
    check("reload_done_tick", done_tick, base + 8);

    // First two samples of A4.
    tick(1, 49, 20, 0, 0, 1);
    tick(0, 0, 0, 0, 1, 1);
    check("a4_sample0", last_sample, -16384);
    tick(0, 0, 0, 0, 1, 1);
    check("a4_sample1", last_sample, -15784);

    // Rest: ten requests give ten zero samples.
    tick(1, 0, 30, 0, 0, 1);
    rdy_seen = 0;
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 1, 1);
    check("rest_ready_count", rdy_seen, 10);
    check("rest_sample", last_sample, 0);

    for (int i = 0; i < 2000; i++) begin
      en = ($urandom % 8) != 0;
      nn = ($urandom % 40) == 0;
      bt = ($urandom % 6) == 0;
      gn = ($urandom % 3) == 0;
      nt = int'($urandom % 64);
      du = int'($urandom % 6);
      if (nn) begin
        en = 1'b1;
        gn = 1'b0;
      end
      tick(nn, nt, du, bt, gn, en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
